// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage: FSM states, MEM/WB control record
// and the default wait-state timeout.
package mem_stage_pkg;

   localparam int MEM_TIMEOUT_DEFAULT = 15;
   localparam int REG_ADDR_LEN        = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic                    wb_en;
      logic                    mem_r_en;
      logic [REG_ADDR_LEN-1:0] dest;
   } mem_wb_ctrl_t;

   function automatic logic is_mem_op(input logic valid, input logic r_en, input logic w_en);
      return valid & (r_en | w_en);
   endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-state counter for the MEM stage: counts stalled access cycles and flags when the
// programmed limit is reached. Saturates at the limit; clear has priority over enable.
module mem_wait_ctr
   import mem_stage_pkg::*;
#(
   parameter int LIMIT = MEM_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(LIMIT + 1) < 1 ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en && (count_reg != CW'(LIMIT))) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign tc = (count_reg == CW'(LIMIT));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EXE/MEM register, data-memory handshake with wait states, MEM/WB register.
// Optional access timeout with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int WORD_LEN    = 32,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WORD_LEN-1:0] ALU_res_in,
   input  logic [WORD_LEN-1:0] ST_value_in,
   input  logic [4:0]          dest_in,
   input  logic                WB_EN_in,
   input  logic                MEM_R_EN_in,
   input  logic                MEM_W_EN_in,
   input  logic                valid_in,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [WORD_LEN-1:0] dmem_addr,
   output logic [WORD_LEN-1:0] dmem_wdata,
   input  logic                dmem_ack,
   input  logic [WORD_LEN-1:0] dmem_rdata,
   output logic                mem_stall,
   output logic [WORD_LEN-1:0] ALU_res_MEM,
   output logic                WB_EN_WB,
   output logic                MEM_R_EN_WB,
   output logic [4:0]          dest_WB,
   output logic [WORD_LEN-1:0] ALU_res_WB,
   output logic [WORD_LEN-1:0] mem_data_WB,
   output logic                bus_err
);

   logic [WORD_LEN-1:0] ex_alu_reg;
   logic [WORD_LEN-1:0] ex_st_reg;
   logic [4:0]          ex_dest_reg;
   logic                ex_wb_reg;
   logic                ex_r_reg;
   logic                ex_w_reg;
   logic                ex_valid_reg;

   mem_state_e          state_reg;
   mem_state_e          state_next;

   mem_wb_ctrl_t        wb_ctrl_reg;
   mem_wb_ctrl_t        wb_ctrl_next;
   logic [WORD_LEN-1:0] wb_alu_reg;
   logic [WORD_LEN-1:0] wb_data_reg;
   logic [WORD_LEN-1:0] wb_data_next;

   logic                acked;
   logic                abort;

   // The entry stays in EXE/MEM until its access completes, so "un-acked" reduces to "present".
   assign dmem_req   = is_mem_op(ex_valid_reg, ex_r_reg, ex_w_reg);
   assign dmem_we    = dmem_req & ex_w_reg;
   assign dmem_addr  = ex_alu_reg;
   assign dmem_wdata = ex_st_reg;

   assign acked      = dmem_req & dmem_ack;
   assign mem_stall  = dmem_req & ~dmem_ack & ~abort;

   assign ALU_res_MEM = ex_alu_reg;

`ifdef MEM_TIMEOUT_EN
   logic tc;
   logic bus_err_reg;

   mem_wait_ctr #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait_ctr (
      .clk (clk),
      .rst (rst),
      .clr (~mem_stall),
      .en  (mem_stall),
      .tc  (tc)
   );

   assign abort = (state_reg == WAIT) & dmem_req & ~dmem_ack & tc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_err_reg <= 1'b0;
      end else if (abort) begin
         bus_err_reg <= 1'b1;
      end
   end

   assign bus_err = bus_err_reg;
`else
   assign abort   = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (dmem_req && !dmem_ack) state_next = WAIT;
         WAIT:    if (!dmem_req || dmem_ack || abort) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A combined read+write is treated as a write: nothing is written back for it.
   always_comb begin
      wb_ctrl_next          = '0;
      wb_ctrl_next.wb_en    = ex_valid_reg & ex_wb_reg & ~ex_w_reg & ~abort;
      wb_ctrl_next.mem_r_en = ex_valid_reg & ex_r_reg & ~ex_w_reg & ~abort;
      wb_ctrl_next.dest     = ex_dest_reg;
      wb_data_next          = (acked && !ex_w_reg) ? dmem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_alu_reg   <= '0;
         ex_st_reg    <= '0;
         ex_dest_reg  <= '0;
         ex_wb_reg    <= 1'b0;
         ex_r_reg     <= 1'b0;
         ex_w_reg     <= 1'b0;
         ex_valid_reg <= 1'b0;
         wb_ctrl_reg  <= '0;
         wb_alu_reg   <= '0;
         wb_data_reg  <= '0;
      end else if (!mem_stall) begin
         ex_alu_reg   <= ALU_res_in;
         ex_st_reg    <= ST_value_in;
         ex_dest_reg  <= dest_in;
         ex_wb_reg    <= WB_EN_in;
         ex_r_reg     <= MEM_R_EN_in;
         ex_w_reg     <= MEM_W_EN_in;
         ex_valid_reg <= valid_in;
         wb_ctrl_reg  <= wb_ctrl_next;
         wb_alu_reg   <= ex_alu_reg;
         wb_data_reg  <= wb_data_next;
      end
   end

   assign WB_EN_WB    = wb_ctrl_reg.wb_en;
   assign MEM_R_EN_WB = wb_ctrl_reg.mem_r_en;
   assign dest_WB     = wb_ctrl_reg.dest;
   assign ALU_res_WB  = wb_alu_reg;
   assign mem_data_WB = wb_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected MEM/WB writebacks, a monitor checks them.
// Timeout expectations follow MEM_TIMEOUT_EN (DUT built with MEM_TIMEOUT=4).
module tb_mem_stage;

   localparam int W = 32;
   localparam logic [W-1:0] JUNK = 32'hBAD0_0BAD;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] ALU_res_in, ST_value_in;
   logic [4:0]   dest_in;
   logic         WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, valid_in;
   logic         dmem_req, dmem_we;
   logic [W-1:0] dmem_addr, dmem_wdata;
   logic         dmem_ack;
   logic [W-1:0] dmem_rdata;
   logic         mem_stall;
   logic [W-1:0] ALU_res_MEM;
   logic         WB_EN_WB, MEM_R_EN_WB;
   logic [4:0]   dest_WB;
   logic [W-1:0] ALU_res_WB, mem_data_WB;
   logic         bus_err;

   always #5 clk = ~clk;

   mem_stage #(
      .WORD_LEN    (W),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ALU_res_in  (ALU_res_in),
      .ST_value_in (ST_value_in),
      .dest_in     (dest_in),
      .WB_EN_in    (WB_EN_in),
      .MEM_R_EN_in (MEM_R_EN_in),
      .MEM_W_EN_in (MEM_W_EN_in),
      .valid_in    (valid_in),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .mem_stall   (mem_stall),
      .ALU_res_MEM (ALU_res_MEM),
      .WB_EN_WB    (WB_EN_WB),
      .MEM_R_EN_WB (MEM_R_EN_WB),
      .dest_WB     (dest_WB),
      .ALU_res_WB  (ALU_res_WB),
      .mem_data_WB (mem_data_WB),
      .bus_err     (bus_err)
   );

   typedef struct {
      logic         wb_en;
      logic         mem_r_en;
      logic [4:0]   dest;
      logic [W-1:0] alu;
      logic [W-1:0] data;
   } wb_rec_t;

   wb_rec_t exp_q[$];
   int      checks = 0;
   int      errors = 0;

   function automatic wb_rec_t mk(input logic wb, input logic r, input logic [4:0] d,
                                  input logic [W-1:0] alu, input logic [W-1:0] data);
      wb_rec_t rec;
      rec.wb_en    = wb;
      rec.mem_r_en = r;
      rec.dest     = d;
      rec.alu      = alu;
      rec.data     = data;
      return rec;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_idle_inputs();
      valid_in    = 1'b0;
      WB_EN_in    = 1'b0;
      MEM_R_EN_in = 1'b0;
      MEM_W_EN_in = 1'b0;
      dest_in     = '0;
      ALU_res_in  = '0;
      ST_value_in = '0;
   endtask

   task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                        input logic [4:0] d, input logic [W-1:0] alu, input logic [W-1:0] st);
      @(negedge clk);
      valid_in    = v;
      WB_EN_in    = wb;
      MEM_R_EN_in = r;
      MEM_W_EN_in = w;
      dest_in     = d;
      ALU_res_in  = alu;
      ST_value_in = st;
   endtask

   // Serves the access currently in EXE/MEM: n_wait stalled cycles, then an ack cycle.
   task automatic mem_access(input int n_wait, input logic [W-1:0] rdata, input logic [W-1:0] addr,
                             input logic we, input logic [W-1:0] wdata, input string tag);
      int stalls = 0;
      for (int i = 0; i < n_wait; i++) begin
         @(negedge clk);
         set_idle_inputs();
         dmem_ack   = 1'b0;
         dmem_rdata = JUNK;
         #1;
         check({tag, "_req_wait"}, dmem_req, 1);
         check({tag, "_addr_wait"}, dmem_addr, addr);
         check({tag, "_we_wait"}, dmem_we, we);
         check({tag, "_wdata_wait"}, dmem_wdata, wdata);
         if (mem_stall) stalls++;
      end
      @(negedge clk);
      set_idle_inputs();
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      #1;
      check({tag, "_req_ack"}, dmem_req, 1);
      check({tag, "_addr_ack"}, dmem_addr, addr);
      check({tag, "_we_ack"}, dmem_we, we);
      check({tag, "_wdata_ack"}, dmem_wdata, wdata);
      check({tag, "_stall_ack"}, mem_stall, 0);
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = JUNK;
      #1;
      check({tag, "_req_after"}, dmem_req, 0);
      check({tag, "_stall_cycles"}, stalls, n_wait);
   endtask

   // Monitor: whenever MEM/WB was loaded with a writeback, pop and compare.
   initial begin
      logic pre_ok;
      wb_rec_t e;
      forever begin
         @(negedge clk);
         #2;
         pre_ok = rst && !mem_stall;
         @(posedge clk);
         #1;
         if (pre_ok && (WB_EN_WB || MEM_R_EN_WB)) begin
            $display("wb: dest=%0d wb_en=%0b r_en=%0b alu=0x%08h data=0x%08h",
                     dest_WB, WB_EN_WB, MEM_R_EN_WB, ALU_res_WB, mem_data_WB);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected: got dest=%0d alu=0x%08h data=0x%08h, required no writeback",
                        dest_WB, ALU_res_WB, mem_data_WB);
            end else begin
               e = exp_q.pop_front();
               if (WB_EN_WB !== e.wb_en || MEM_R_EN_WB !== e.mem_r_en || dest_WB !== e.dest ||
                   ALU_res_WB !== e.alu || mem_data_WB !== e.data) begin
                  errors++;
                  $display("FAIL wb_record: got wb=%0b r=%0b dest=%0d alu=0x%08h data=0x%08h required wb=%0b r=%0b dest=%0d alu=0x%08h data=0x%08h",
                           WB_EN_WB, MEM_R_EN_WB, dest_WB, ALU_res_WB, mem_data_WB,
                           e.wb_en, e.mem_r_en, e.dest, e.alu, e.data);
               end
            end
         end
      end
   end

   initial begin
      rst        = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = JUNK;
      set_idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", dmem_req, 0);
      check("rst_stall", mem_stall, 0);
      check("rst_alu_mem", ALU_res_MEM, 0);
      check("rst_wb_en", WB_EN_WB, 0);
      check("rst_alu_wb", ALU_res_WB, 0);
      check("rst_bus_err", bus_err, 0);
      rst = 1'b1;

      // ALU op: one cycle to EXE/MEM, one more to WB
      exp_q.push_back(mk(1'b1, 1'b0, 5'd5, 32'h10, 32'h0));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_0010, 32'h0);
      @(negedge clk);
      set_idle_inputs();
      #1;
      check("alu_mem_fwd", ALU_res_MEM, 32'h10);
      check("alu_no_req", dmem_req, 0);
      check("alu_no_stall", mem_stall, 0);
      @(negedge clk);
      #1;
      check("alu_wb_val", ALU_res_WB, 32'h10);
      check("alu_wb_dest", dest_WB, 5);
      check("alu_wb_en", WB_EN_WB, 1);

      // Load with three wait states
      exp_q.push_back(mk(1'b1, 1'b1, 5'd7, 32'h100, 32'hDEAD_BEEF));
      drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0100, 32'h0);
      mem_access(3, 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h0, "ld");
      check("ld_mem_data", mem_data_WB, 32'hDEAD_BEEF);
      check("ld_r_en_wb", MEM_R_EN_WB, 1);

      // Store acked in the request cycle
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0104, 32'h1234_5678);
      mem_access(0, JUNK, 32'h104, 1'b1, 32'h1234_5678, "st");
      check("st_wb_en", WB_EN_WB, 0);

      // Read and write both set behaves as a write with no writeback
      drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_0108, 32'hCAFE_F00D);
      mem_access(1, 32'h7777_7777, 32'h108, 1'b1, 32'hCAFE_F00D, "rw");
      check("rw_wb_en", WB_EN_WB, 0);
      check("rw_mem_data", mem_data_WB, 0);

      // Back-to-back ALU ops, one without writeback, one invalid
      exp_q.push_back(mk(1'b1, 1'b0, 5'd1, 32'hA1, 32'h0));
      exp_q.push_back(mk(1'b1, 1'b0, 5'd4, 32'hD4, 32'h0));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'hA1, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'hB2, 32'h0);
      #1 check("b2b_mem_a", ALU_res_MEM, 32'hA1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'hC3, 32'h0);
      #1 check("b2b_mem_b", ALU_res_MEM, 32'hB2);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'hD4, 32'h0);
      #1 check("b2b_mem_c", ALU_res_MEM, 32'hC3);
      @(negedge clk);
      set_idle_inputs();
      #1 check("b2b_mem_d", ALU_res_MEM, 32'hD4);
      repeat (2) @(negedge clk);

      // Reset during WAIT, then a late ack
      drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0200, 32'h0);
      @(negedge clk);
      set_idle_inputs();
      #1;
      check("rstw_req", dmem_req, 1);
      check("rstw_stall", mem_stall, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst        = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h5555_5555;
      #1;
      check("rstw_req_after", dmem_req, 0);
      check("rstw_stall_after", mem_stall, 0);
      check("rstw_alu_mem", ALU_res_MEM, 0);
      check("rstw_wb_en", WB_EN_WB, 0);
      check("rstw_dest", dest_WB, 0);
      check("rstw_alu_wb", ALU_res_WB, 0);
      check("rstw_data", mem_data_WB, 0);
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = JUNK;
      #1;
      check("rstw_late_wb_en", WB_EN_WB, 0);
      check("rstw_late_data", mem_data_WB, 0);

      // Load that never gets acked on its own
`ifdef MEM_TIMEOUT_EN
      drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_idle_inputs();
         #1;
         check("to_stall", mem_stall, 1);
         check("to_bus_err_pre", bus_err, 0);
      end
      @(negedge clk);
      #1;
      check("to_released", mem_stall, 0);
      @(negedge clk);
      #1;
      check("to_req_off", dmem_req, 0);
      check("to_bus_err", bus_err, 1);
      check("to_wb_en", WB_EN_WB, 0);
      check("to_data", mem_data_WB, 0);
      repeat (3) @(negedge clk);
      #1 check("to_bus_err_held", bus_err, 1);
`else
      exp_q.push_back(mk(1'b1, 1'b1, 5'd3, 32'h300, 32'h0BAD_F00D));
      drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0300, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         set_idle_inputs();
         #1;
         check("to_stall", mem_stall, 1);
         check("to_bus_err", bus_err, 0);
      end
      mem_access(0, 32'h0BAD_F00D, 32'h300, 1'b0, 32'h0, "to");
`endif

      // Zero-wait load afterwards
      exp_q.push_back(mk(1'b1, 1'b1, 5'd11, 32'h400, 32'hA5A5_A5A5));
      drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0400, 32'h0);
      mem_access(0, 32'hA5A5_A5A5, 32'h400, 1'b0, 32'h0, "ld0");

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
